// File: rtl/gcn_coo_aggregate_argmax.sv
// gcn_coo_aggregate_argmax: walks a COO edge list, accumulates A*FW per node with optional
// self-loops and symmetric edges, then emits a per-node argmax class index.
module gcn_coo_aggregate_argmax #(
    parameter int NUM_NODES   = 6,
    parameter int NUM_CLASSES = 3,
    parameter int NUM_EDGES   = 6,
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = DATA_WIDTH + 4,
    parameter int NODE_BW     = $clog2(NUM_NODES + 1),
    parameter int CLASS_BW    = $clog2(NUM_CLASSES),
    parameter int COO_BASE    = 1,
    parameter bit SYMMETRIC   = 1'b0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              self_loop_en,
    output logic [$clog2(NUM_EDGES)-1:0]      coo_address,
    input  logic [2*NODE_BW-1:0]              coo_in,
    output logic [$clog2(NUM_NODES)-1:0]      fw_rd_addr,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] fw_rd_data,
    output logic                              busy,
    output logic                              done,
    output logic                              err_flag,
    output logic [NUM_NODES*CLASS_BW-1:0]     max_addr
);
    localparam int EW = $clog2(NUM_EDGES);
    localparam int AW = $clog2(NUM_NODES);

    typedef enum logic [2:0] {IDLE, CLEAR, EDGE, SELF, ARGMAX, DONE} state_t;

    state_t                        state_q, state_d;
    logic [1:0]                    phase_q, phase_d;
    logic [EW-1:0]                 coo_address_q, coo_address_d;
    logic [NODE_BW-1:0]            node_q, node_d;
    logic [AW-1:0]                 fw_rd_addr_q, fw_rd_addr_d;
    logic [AW-1:0]                 pend_node_q, pend_node_d;
    logic                          pend_q, pend_d;
    logic                          self_q, self_d;
    logic                          err_q, err_d;
    logic [NUM_NODES*CLASS_BW-1:0] max_q, max_d;
    logic [ACC_WIDTH-1:0]          acc_q [NUM_NODES][NUM_CLASSES];
    logic [ACC_WIDTH-1:0]          acc_d [NUM_NODES][NUM_CLASSES];
    logic [NODE_BW-1:0]            src, dst;
    logic                          bad, adv, last_edge, last_node;
    logic [ACC_WIDTH-1:0]          best;
    logic [CLASS_BW-1:0]           best_idx;

    function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + (ACC_WIDTH + 1)'(b);
        return s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
    endfunction

    // Raw indices wrap in NODE_BW bits, so values below COO_BASE land out of range too.
    assign src       = coo_in[2*NODE_BW-1 -: NODE_BW] - NODE_BW'(COO_BASE);
    assign dst       = coo_in[NODE_BW-1:0] - NODE_BW'(COO_BASE);
    assign bad       = (src >= NODE_BW'(NUM_NODES)) || (dst >= NODE_BW'(NUM_NODES));
    assign last_edge = coo_address_q == EW'(NUM_EDGES - 1);
    assign last_node = node_q == NODE_BW'(NUM_NODES - 1);

    always_comb begin
        best     = acc_q[node_q][0];
        best_idx = '0;
        for (int c = 1; c < NUM_CLASSES; c++)
            if (acc_q[node_q][c] > best) begin
                best     = acc_q[node_q][c];
                best_idx = CLASS_BW'(c);
            end
    end

    // A row requested in one cycle is added the cycle after next, via the pend_* stage;
    // ARGMAX spends its first cycle letting the final pending add land.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        coo_address_d = coo_address_q;
        node_d        = node_q;
        fw_rd_addr_d  = fw_rd_addr_q;
        pend_d        = 1'b0;
        pend_node_d   = pend_node_q;
        self_d        = self_q;
        err_d         = err_q;
        max_d         = max_q;
        acc_d         = acc_q;
        adv           = 1'b0;
        if (pend_q)
            for (int c = 0; c < NUM_CLASSES; c++)
                acc_d[pend_node_q][c] = sat_add(acc_q[pend_node_q][c],
                                                fw_rd_data[c*DATA_WIDTH +: DATA_WIDTH]);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    self_d  = self_loop_en;
                    err_d   = 1'b0;
                end
            end
            CLEAR: begin
                acc_d         = '{default: '0};
                coo_address_d = '0;
                phase_d       = '0;
                state_d       = EDGE;
            end
            EDGE: begin
                phase_d = phase_q + 2'd1;
                case (phase_q)
                    2'd0: begin
                        fw_rd_addr_d = bad ? fw_rd_addr_q : AW'(src);
                        err_d        = err_q | bad;
                    end
                    2'd1: begin
                        pend_d      = !bad;
                        pend_node_d = AW'(dst);
                        adv         = bad || !SYMMETRIC || (src == dst);
                    end
                    2'd2: fw_rd_addr_d = AW'(dst);
                    default: begin
                        pend_d      = 1'b1;
                        pend_node_d = AW'(src);
                        adv         = 1'b1;
                    end
                endcase
                if (adv) begin
                    phase_d       = '0;
                    node_d        = '0;
                    coo_address_d = coo_address_q + EW'(1);
                    if (last_edge)
                        state_d = self_q ? SELF : ARGMAX;
                end
            end
            SELF: begin
                phase_d = phase_q ^ 2'd1;
                if (phase_q == 2'd0)
                    fw_rd_addr_d = AW'(node_q);
                else begin
                    pend_d      = 1'b1;
                    pend_node_d = AW'(node_q);
                    node_d      = last_node ? '0 : node_q + NODE_BW'(1);
                    state_d     = last_node ? ARGMAX : SELF;
                end
            end
            ARGMAX: begin
                phase_d = 2'd1;
                if (phase_q != 2'd0) begin
                    max_d[node_q*CLASS_BW +: CLASS_BW] = best_idx;
                    node_d  = node_q + NODE_BW'(1);
                    state_d = last_node ? DONE : ARGMAX;
                end
            end
            DONE: state_d = start ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            coo_address_q <= '0;
            node_q        <= '0;
            fw_rd_addr_q  <= '0;
            pend_node_q   <= '0;
            pend_q        <= 1'b0;
            self_q        <= 1'b0;
            err_q         <= 1'b0;
            max_q         <= '0;
            acc_q         <= '{default: '0};
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            coo_address_q <= coo_address_d;
            node_q        <= node_d;
            fw_rd_addr_q  <= fw_rd_addr_d;
            pend_node_q   <= pend_node_d;
            pend_q        <= pend_d;
            self_q        <= self_d;
            err_q         <= err_d;
            max_q         <= max_d;
            acc_q         <= acc_d;
        end
    end

    assign coo_address = coo_address_q;
    assign fw_rd_addr  = fw_rd_addr_q;
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = state_q == DONE;
    assign err_flag    = err_q;
    assign max_addr    = max_q;
endmodule

// File: tb/tb_gcn_coo_aggregate_argmax.sv
// tb_gcn_coo_aggregate_argmax: table vectors, hand sequences and random graphs checked
// against a plain-arithmetic model of A*FW aggregation and argmax.
module tb_gcn_coo_aggregate_argmax;
    localparam int N = 6;
    localparam int C = 3;
    localparam int DW = 16;
    localparam longint SAT = (64'd1 << 20) - 1;

    typedef struct {
        logic [17:0] src;
        logic [17:0] dst;
        int          mode;
        bit          slf;
        logic [11:0] emax;
        bit          eerr;
        int          ecyc;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic self_loop_en = 1'b0;
    logic [2:0] m_src [32];
    logic [2:0] m_dst [32];
    logic [DW-1:0] m_fw [N][C];
    logic [2:0] coo_addr_a, fw_addr_a, fw_addr_b;
    logic [4:0] coo_addr_b;
    logic [C*DW-1:0] row_a, row_b, fw_data_a, fw_data_b;
    logic busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [11:0] max_a, max_b;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb
        for (int c = 0; c < C; c++) begin
            row_a[c*DW +: DW] = m_fw[fw_addr_a][c];
            row_b[c*DW +: DW] = m_fw[fw_addr_b][c];
        end

    always_ff @(posedge clk) begin
        fw_data_a <= row_a;
        fw_data_b <= row_b;
    end

    gcn_coo_aggregate_argmax dut_a (
        .clk(clk), .reset(reset), .start(start_a), .self_loop_en(self_loop_en),
        .coo_address(coo_addr_a), .coo_in({m_src[coo_addr_a], m_dst[coo_addr_a]}),
        .fw_rd_addr(fw_addr_a), .fw_rd_data(fw_data_a),
        .busy(busy_a), .done(done_a), .err_flag(err_a), .max_addr(max_a)
    );

    gcn_coo_aggregate_argmax #(.NUM_EDGES(32), .SYMMETRIC(1'b1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .self_loop_en(self_loop_en),
        .coo_address(coo_addr_b), .coo_in({m_src[coo_addr_b], m_dst[coo_addr_b]}),
        .fw_rd_addr(fw_addr_b), .fw_rd_data(fw_data_b),
        .busy(busy_b), .done(done_b), .err_flag(err_b), .max_addr(max_b)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic set_fw(input int mode);
        for (int n = 0; n < N; n++)
            for (int c = 0; c < C; c++)
                m_fw[n][c] = mode == 1 ? DW'(7) :
                             mode == 2 ? (c == 2 ? DW'(3 * n) : DW'(3)) :
                             (c == 0 ? DW'(5) : c == 1 ? DW'(10) : DW'(n + 1));
    endtask

    function automatic logic [2:0] rnd_node();
        if ($urandom_range(0, 9) == 0)
            return $urandom_range(0, 1) ? 3'd0 : 3'd7;
        return 3'($urandom_range(1, 6));
    endfunction

    function automatic longint sat(input longint v);
        return v > SAT ? SAT : v;
    endfunction

    // Node sums are order-independent, so saturation can be applied once at the end.
    function automatic void model(input int ne, input bit sym, input bit slf,
                                  output logic [11:0] emax, output bit eerr, output int ecyc);
        longint acc [N][C];
        int s, d, bi;
        for (int n = 0; n < N; n++)
            for (int c = 0; c < C; c++)
                acc[n][c] = slf ? longint'(m_fw[n][c]) : 0;
        eerr = 1'b0;
        ecyc = 2 + N + (slf ? 2 * N : 0);
        for (int e = 0; e < ne; e++) begin
            s = int'(m_src[e]) - 1;
            d = int'(m_dst[e]) - 1;
            if (s < 0 || s >= N || d < 0 || d >= N) begin
                eerr = 1'b1;
                ecyc += 2;
            end else begin
                ecyc += (sym && s != d) ? 4 : 2;
                for (int c = 0; c < C; c++) begin
                    acc[d][c] += longint'(m_fw[s][c]);
                    if (sym && s != d)
                        acc[s][c] += longint'(m_fw[d][c]);
                end
            end
        end
        emax = '0;
        for (int n = 0; n < N; n++) begin
            bi = 0;
            for (int c = 1; c < C; c++)
                if (sat(acc[n][c]) > sat(acc[n][bi]))
                    bi = c;
            emax[n*2 +: 2] = 2'(bi);
        end
    endfunction

    task automatic run(input bit inst, input bit slf, input logic [11:0] emax,
                       input bit eerr, input int ecyc, input string name);
        int cyc;
        bit got;
        repeat (2) @(negedge clk);
        self_loop_en = slf;
        if (inst)
            start_b = 1'b1;
        else
            start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 400) begin
            @(posedge clk);
            cyc++;
            #1;
            got = inst ? done_b : done_a;
        end
        check($sformatf("%s done", name), longint'(got), 1);
        check($sformatf("%s cycles", name), cyc, ecyc);
        check($sformatf("%s max_addr", name), inst ? max_b : max_a, emax);
        check($sformatf("%s err_flag", name), inst ? err_b : err_a, longint'(eerr));
        check($sformatf("%s busy", name), inst ? busy_b : busy_a, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [5];
        logic [11:0] emax;
        bit eerr;
        int ecyc;
        bit slf;
        tbl[0] = '{18'o654321, 18'o165432, 0, 1'b0, 12'h555, 1'b0, 20};
        tbl[1] = '{18'o654321, 18'o165432, 1, 1'b0, 12'h000, 1'b0, 20};
        tbl[2] = '{18'o654321, 18'o165432, 2, 1'b0, 12'hA82, 1'b0, 20};
        tbl[3] = '{18'o654321, 18'o165032, 0, 1'b0, 12'h515, 1'b1, 20};
        tbl[4] = '{18'o654321, 18'o175432, 0, 1'b1, 12'h555, 1'b1, 32};
        for (int e = 0; e < 32; e++) begin
            m_src[e] = 3'd1;
            m_dst[e] = 3'd1;
        end
        set_fw(0);

        repeat (3) @(posedge clk);
        #1;
        check("reset done_a", done_a, 0);
        check("reset busy_a", busy_a, 0);
        check("reset err_a", err_a, 0);
        check("reset max_a", max_a, 0);
        check("reset coo_addr_a", coo_addr_a, 0);
        check("reset fw_addr_a", fw_addr_a, 0);
        check("reset done_b", done_b, 0);
        check("reset busy_b", busy_b, 0);
        check("reset max_b", max_b, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            for (int e = 0; e < N; e++) begin
                m_src[e] = tbl[i].src[e*3 +: 3];
                m_dst[e] = tbl[i].dst[e*3 +: 3];
            end
            set_fw(tbl[i].mode);
            run(1'b0, tbl[i].slf, tbl[i].emax, tbl[i].eerr, tbl[i].ecyc, $sformatf("vec%0d", i));
        end

        // start held high keeps DONE; dropping it returns to IDLE with max_addr held
        @(negedge clk);
        start_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("hold done", done_a, 1);
        check("hold busy", busy_a, 0);
        @(negedge clk);
        start_a = 1'b0;
        @(posedge clk);
        #1;
        check("release done", done_a, 0);
        check("stale max_addr", max_a, tbl[4].emax);

        // reset in the middle of the edge walk, after the bad edge flagged an error
        @(negedge clk);
        self_loop_en = 1'b1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("mid busy", busy_a, 1);
        check("mid err", err_a, 1);
        #1 reset = 1'b1;
        #1;
        check("async done", done_a, 0);
        check("async busy", busy_a, 0);
        check("async max", max_a, 0);
        check("async err", err_a, 0);
        @(negedge clk);
        reset = 1'b0;
        run(1'b0, 1'b1, 12'h555, 1'b1, 32, "post_reset");

        for (int i = 0; i < 25; i++) begin
            for (int e = 0; e < N; e++) begin
                m_src[e] = rnd_node();
                m_dst[e] = rnd_node();
            end
            for (int n = 0; n < N; n++)
                for (int c = 0; c < C; c++)
                    m_fw[n][c] = $urandom_range(0, 1) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            slf = 1'($urandom_range(0, 1));
            model(N, 1'b0, slf, emax, eerr, ecyc);
            run(1'b0, slf, emax, eerr, ecyc, $sformatf("rand_a%0d", i));
        end

        // symmetric edge (1,2) plus zero-row self-edges, self-loops on
        for (int e = 0; e < 32; e++) begin
            m_src[e] = 3'd3;
            m_dst[e] = 3'd3;
        end
        m_src[0] = 3'd1;
        m_dst[0] = 3'd2;
        for (int n = 0; n < N; n++)
            for (int c = 0; c < C; c++)
                m_fw[n][c] = '0;
        m_fw[0][2] = 16'd9;
        m_fw[1][0] = 16'd4;
        run(1'b1, 1'b1, 12'h00A, 1'b0, 86, "sym_self");

        // 32 self-edges into node 0: c0 and c2 saturate, c1 stays just below the limit
        for (int e = 0; e < 32; e++) begin
            m_src[e] = 3'd1;
            m_dst[e] = 3'd1;
        end
        m_fw[0][0] = 16'h8000;
        m_fw[0][1] = 16'h7FFF;
        m_fw[0][2] = 16'hFFFF;
        run(1'b1, 1'b0, 12'h000, 1'b0, 72, "saturate");

        for (int i = 0; i < 4; i++) begin
            for (int e = 0; e < 32; e++) begin
                m_src[e] = rnd_node();
                m_dst[e] = rnd_node();
            end
            for (int n = 0; n < N; n++)
                for (int c = 0; c < C; c++)
                    m_fw[n][c] = DW'($urandom);
            slf = 1'($urandom_range(0, 1));
            model(32, 1'b1, slf, emax, eerr, ecyc);
            run(1'b1, slf, emax, eerr, ecyc, $sformatf("rand_b%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
